branch_resolver: RTL

Resolution-side partner of the saturating-counter predictor. It records each prediction issued at fetch in an in-order queue. When the branch resolves, it compares the actual outcome with the oldest queued prediction and produces the registered `branch`/`taken` training pulse that drives the predictor. It also signals mispredictions, flushes younger speculative entries, and keeps saturating statistics counters.

---
 rtl/branch_resolver.sv | 104 ++++++++++
 1 files changed

// File: rtl/branch_resolver.sv
// Resolution-side partner of the saturating-counter predictor: queues issued
// predictions in order, checks them against resolved outcomes, and emits training/flush pulses.
module branch_resolver #(
  parameter int DEPTH = 4,
  parameter int CW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pred_valid,
  input  logic          pred_taken,
  input  logic          res_valid,
  input  logic          res_taken,
  output logic          branch,
  output logic          taken,
  output logic          mispredict,
  output logic          full,
  output logic          empty,
  output logic          overflow,
  output logic          underflow,
  output logic [CW-1:0] br_count,
  output logic [CW-1:0] mp_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      cnt;

  logic vld_p0;
  logic mis_p0;
  logic push_p0;
  logic drop_p0;
  logic unf_p0;

  logic vld_p1;
  logic taken_p1;
  logic mis_p1;

  assign full  = (cnt == CNT_FULL);
  assign empty = (cnt == '0);

  // Stage p0: decisions from pre-edge state
  always_comb begin
    vld_p0  = res_valid && !empty;
    unf_p0  = res_valid && empty;
    mis_p0  = vld_p0 && (mem[rd_ptr] != res_taken);
    // a flushing pop also discards the younger push in the same cycle
    push_p0 = pred_valid && !mis_p0 && (!full || vld_p0);
    drop_p0 = pred_valid && !mis_p0 && full && !vld_p0;
  end

  always_ff @(posedge clk) begin
    if (push_p0) mem[wr_ptr] <= pred_taken;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (mis_p0) begin
      rd_ptr <= rd_ptr + AW'(1);
      wr_ptr <= rd_ptr + AW'(1);
      cnt    <= '0;
    end else begin
      rd_ptr <= rd_ptr + AW'(vld_p0);
      wr_ptr <= wr_ptr + AW'(push_p0);
      cnt    <= cnt + (AW+1)'(push_p0) - (AW+1)'(vld_p0);
    end
  end

  // Stage p1: registered training pulse, status and statistics
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      taken_p1  <= 1'b0;
      mis_p1    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      br_count  <= '0;
      mp_count  <= '0;
    end else begin
      vld_p1   <= vld_p0;
      taken_p1 <= vld_p0 && res_taken;
      mis_p1   <= mis_p0;
      if (drop_p0) overflow <= 1'b1;
      if (unf_p0)  underflow <= 1'b1;
      if (vld_p0)  br_count <= sat_inc(br_count);
      if (mis_p0)  mp_count <= sat_inc(mp_count);
    end
  end

  assign branch     = vld_p1;
  assign taken      = taken_p1;
  assign mispredict = mis_p1;

endmodule
